// File: rtl/cnt_down.sv
// Programmable down-counter with an internal prescaler.
// One-shot mode stops at 0; auto mode wraps 0 -> MAXV. tick is a one-cycle enable, not a clock.
module cnt_down #(
    parameter int DIV  = 5,
    parameter int MAXV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       start,
    input  logic       pause,
    input  logic       auto,
    output logic [3:0] out,
    output logic       tick,
    output logic       done,
    output logic       busy
);

    localparam int PW = ($clog2(DIV) < 3) ? 3 : $clog2(DIV);
    localparam logic [PW-1:0] PTOP = PW'(DIV - 1);
    localparam logic [3:0]    MAXC = 4'(MAXV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [3:0]    out_nxt;
    logic          tick_nxt, done_nxt;

    function automatic logic [3:0] clamp_load(input logic [3:0] v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        out_nxt   = out;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (load) begin
            out_nxt   = clamp_load(load_val);
            pcnt_nxt  = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    pcnt_nxt = '0;
                    if (start && !pause)
                        state_nxt = (out == 4'd0 && !auto) ? DONE : RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (pcnt == PTOP) begin
                        pcnt_nxt = '0;
                        tick_nxt = 1'b1;
                        if (out != 4'd0) begin
                            out_nxt = out - 4'd1;
                            if (out == 4'd1) begin
                                done_nxt = 1'b1;
                                if (!auto)
                                    state_nxt = DONE;
                            end
                        end else if (auto) begin
                            out_nxt = MAXC;
                        end else begin
                            // Only reachable if auto was dropped while sitting at 0.
                            state_nxt = DONE;
                        end
                    end else begin
                        pcnt_nxt = pcnt + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        if (out == 4'd0 && !auto) begin
                            state_nxt = DONE;
                            pcnt_nxt  = '0;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                DONE: begin
                    pcnt_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    pcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            pcnt  <= '0;
            out   <= 4'd0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            out   <= out_nxt;
            tick  <= tick_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_cnt_down.sv
// Directed test-plan steps followed by a randomized phase checked against a
// behavioural model of the counter (DIV=5, MAXV=10).
module tb_cnt_down;

    localparam int DIV  = 5;
    localparam int MAXV = 10;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       auto;
    logic [3:0] out;
    logic       tick;
    logic       done;
    logic       busy;

    int ntests = 0;
    int nfail  = 0;

    cnt_down #(.DIV(DIV), .MAXV(MAXV)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .auto(auto),
        .out(out), .tick(tick), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: progress is counted in RUN cycles; every DIV of them is one step.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_out = 0, m_prog = 0, m_mode = M_IDLE;
    bit m_tick = 0, m_done = 0;

    always @(posedge clk) begin
        m_tick = 0;
        m_done = 0;
        if (!rst) begin
            m_out = 0; m_prog = 0; m_mode = M_IDLE;
        end else if (load) begin
            m_out  = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_prog = 0;
            m_mode = M_IDLE;
        end else if (m_mode == M_RUN) begin
            if (pause) begin
                m_mode = M_PAUSED;
            end else begin
                m_prog = m_prog + 1;
                if (m_prog == DIV) begin
                    m_prog = 0;
                    m_tick = 1;
                    if (m_out > 0) begin
                        m_out = m_out - 1;
                        if (m_out == 0) begin
                            m_done = 1;
                            if (!auto) m_mode = M_DONE;
                        end
                    end else if (auto) begin
                        m_out = MAXV;
                    end else begin
                        m_mode = M_DONE;
                    end
                end
            end
        end else if ((m_mode == M_IDLE || m_mode == M_PAUSED) && start && !pause) begin
            if (m_out == 0 && !auto) begin
                m_mode = M_DONE;
                m_prog = 0;
            end else begin
                m_mode = M_RUN;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int ndone, ntick;

    initial begin
        rst = 1'b0; load = 1'b0; load_val = 4'd0; start = 1'b0; pause = 1'b0; auto = 1'b0;
        cyc(2);
        chk("reset_out", {4'd0, out}, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_tick", {7'd0, tick}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        rst = 1'b1;

        // Reset mid-RUN
        load = 1'b1; load_val = 4'd7; cyc(1);
        load = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        chk("rst_run_busy", {7'd0, busy}, 8'd1);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (done) ndone++;
        end
        chk("rst_run_out_before", {4'd0, out}, 8'd5);
        rst = 1'b0; cyc(1); rst = 1'b1;
        if (done) ndone++;
        chk("rst_run_out", {4'd0, out}, 8'd0);
        chk("rst_run_busy_after", {7'd0, busy}, 8'd0);
        chk("rst_run_no_done", 8'(ndone), 8'd0);

        // One-shot from 3
        load = 1'b1; load_val = 4'd3; auto = 1'b0; cyc(1);
        load = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        chk("os_out_e0", {4'd0, out}, 8'd3);
        cyc(4);
        chk("os_out_e4", {4'd0, out}, 8'd3);
        chk("os_tick_e4", {7'd0, tick}, 8'd0);
        cyc(1);
        chk("os_out_e5", {4'd0, out}, 8'd2);
        chk("os_tick_e5", {7'd0, tick}, 8'd1);
        cyc(5);
        chk("os_out_e10", {4'd0, out}, 8'd1);
        cyc(4);
        chk("os_done_e14", {7'd0, done}, 8'd0);
        chk("os_busy_e14", {7'd0, busy}, 8'd1);
        cyc(1);
        chk("os_out_e15", {4'd0, out}, 8'd0);
        chk("os_done_e15", {7'd0, done}, 8'd1);
        chk("os_busy_e15", {7'd0, busy}, 8'd0);
        cyc(1);
        chk("os_done_e16", {7'd0, done}, 8'd0);
        start = 1'b1; cyc(1); start = 1'b0; cyc(6);
        chk("os_restart_out", {4'd0, out}, 8'd0);
        chk("os_restart_busy", {7'd0, busy}, 8'd0);

        // Auto wrap from 2
        load = 1'b1; load_val = 4'd2; auto = 1'b1; cyc(1);
        load = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        cyc(10);
        chk("au_out_e10", {4'd0, out}, 8'd0);
        chk("au_done_e10", {7'd0, done}, 8'd1);
        ndone = 0; ntick = 0;
        for (int i = 0; i < (MAXV + 1) * DIV; i++) begin
            cyc(1);
            if (done) ndone++;
            if (tick) ntick++;
            if (i == DIV - 1) chk("au_reload", {4'd0, out}, 8'(MAXV));
        end
        chk("au_out_wrap", {4'd0, out}, 8'd0);
        chk("au_done_wrap", {7'd0, done}, 8'd1);
        chk("au_ndone", 8'(ndone), 8'd1);
        chk("au_ntick", 8'(ntick), 8'(MAXV + 1));
        chk("au_busy", {7'd0, busy}, 8'd1);

        // Pause/resume: 20 non-progress cycles from the pause edge through the resume edge
        load = 1'b1; load_val = 4'd4; auto = 1'b0; cyc(1);
        load = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        cyc(2);
        pause = 1'b1; cyc(19);
        chk("pa_out_held", {4'd0, out}, 8'd4);
        chk("pa_busy_held", {7'd0, busy}, 8'd1);
        pause = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        chk("pa_out_resume", {4'd0, out}, 8'd4);
        cyc(2);
        chk("pa_out_e24", {4'd0, out}, 8'd4);
        cyc(1);
        chk("pa_out_e25", {4'd0, out}, 8'd3);
        chk("pa_tick_e25", {7'd0, tick}, 8'd1);

        // Clamp and priority
        load = 1'b1; load_val = 4'd15; cyc(1);
        load = 1'b0;
        chk("cl_out", {4'd0, out}, 8'(MAXV));
        load = 1'b1; load_val = 4'd6; start = 1'b1; cyc(1);
        load = 1'b0; start = 1'b0;
        chk("ld_st_out", {4'd0, out}, 8'd6);
        chk("ld_st_busy", {7'd0, busy}, 8'd0);
        cyc(6);
        chk("ld_st_nocount", {4'd0, out}, 8'd6);
        start = 1'b1; cyc(1);
        pause = 1'b1; cyc(1);
        pause = 1'b0; start = 1'b0;
        cyc(8);
        chk("ps_busy", {7'd0, busy}, 8'd1);
        chk("ps_out", {4'd0, out}, 8'd6);

        // Zero start
        load = 1'b1; load_val = 4'd0; auto = 1'b0; cyc(1);
        load = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0;
        chk("zs_busy", {7'd0, busy}, 8'd0);
        chk("zs_done", {7'd0, done}, 8'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            cyc(1);
            if (done || busy) ndone++;
        end
        start = 1'b0;
        chk("zs_stays_done", 8'(ndone), 8'd0);
        load = 1'b1; load_val = 4'd5; cyc(1);
        load = 1'b0;
        chk("zs_reload_out", {4'd0, out}, 8'd5);
        start = 1'b1; cyc(1);
        start = 1'b0;
        chk("zs_idle_to_run", {7'd0, busy}, 8'd1);

        // Randomized phase against the reference model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 3) == 0);
            pause    = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) auto = ~auto;
            cyc(1);
            chk("rnd_out", {4'd0, out}, 8'(m_out));
            chk("rnd_tick", {7'd0, tick}, {7'd0, m_tick});
            chk("rnd_done", {7'd0, done}, {7'd0, m_done});
            chk("rnd_busy", {7'd0, busy}, {7'd0, (m_mode == M_RUN || m_mode == M_PAUSED)});
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
